// File: rtl/dht11_ctrl.sv
// -----------------------------------------------------------------------------
// dht11_ctrl
//   Single-wire protocol engine for the DHT11 humidity/temperature sensor.
//   A start request sends the host start pulse, then the engine follows the
//   sensor's response, captures the 40-bit frame MSB first and checks the
//   checksum. The results feed the read registers of the AXI4-Lite block.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   start         one-cycle measurement request (ignored while busy)
//   dht_io        open-drain sensor line: driven 0 by the host, else Z
//   busy          high from an accepted start until the transaction ends
//   done          one-cycle pulse at the end of every transaction
//   hum_int/hum_dec/tem_int/tem_dec  data bytes of the last good frame
//   checksum_err  sticky until the next accepted start
//   timeout_err   sticky until the next accepted start
//   state_dbg     current FSM state encoding
// -----------------------------------------------------------------------------
module dht11_ctrl #(
    parameter int CLK_FREQ_HZ   = 100_000_000,
    parameter int START_LOW_US  = 18000,
    parameter int TIMEOUT_US    = 255,
    parameter int BIT_THRESH_US = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    inout  wire        dht_io,
    output logic       busy,
    output logic       done,
    output logic [7:0] hum_int,
    output logic [7:0] hum_dec,
    output logic [7:0] tem_int,
    output logic [7:0] tem_dec,
    output logic       checksum_err,
    output logic       timeout_err,
    output logic [2:0] state_dbg
);

    localparam int TICK_DIV_RAW = CLK_FREQ_HZ / 1_000_000;
    localparam int TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;
    localparam int TICK_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    localparam int US_W = 15;
    localparam logic [US_W-1:0] US_MAX         = '1;
    localparam logic [US_W-1:0] START_LOW_CNT  = US_W'(START_LOW_US);
    localparam logic [US_W-1:0] TIMEOUT_CNT    = US_W'(TIMEOUT_US);
    localparam logic [US_W-1:0] BIT_THRESH_CNT = US_W'(BIT_THRESH_US);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START_LOW = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_RESP_LOW  = 3'd3,
        S_RESP_HIGH = 3'd4,
        S_BIT_LOW   = 3'd5,
        S_BIT_HIGH  = 3'd6,
        S_CHECK     = 3'd7
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [TICK_W-1:0] tick_cnt_reg;
    logic              us_tick;
    logic [US_W-1:0]   us_cnt_reg;
    logic [1:0]        sync_reg;
    logic              line_prev_reg;
    logic              line_s;
    logic              line_rise;
    logic              line_fall;
    logic [5:0]        bit_cnt_reg;
    logic [39:0]       shift_reg;
    logic [7:0]        frame_byte [5];
    logic [7:0]        sum_calc;
    logic              timeout_hit;
    logic              drive_low;

    logic       done_reg;
    logic       checksum_err_reg;
    logic       timeout_err_reg;
    logic [7:0] hum_int_reg;
    logic [7:0] hum_dec_reg;
    logic [7:0] tem_int_reg;
    logic [7:0] tem_dec_reg;

    // Open-drain: only ever pull low, otherwise let the pull-up win.
    assign dht_io = drive_low ? 1'b0 : 1'bz;

    // Free-running microsecond tick.
    assign us_tick = (tick_cnt_reg == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_reg <= '0;
        end else if (us_tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    // Two-flop synchronizer plus one history flop for edge detection.
    // Reset to 1 so the idle (pulled-up) line does not look like a rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg      <= 2'b11;
            line_prev_reg <= 1'b1;
        end else begin
            sync_reg      <= {sync_reg[0], dht_io};
            line_prev_reg <= sync_reg[1];
        end
    end

    assign line_s    = sync_reg[1];
    assign line_rise = line_s & ~line_prev_reg;
    assign line_fall = ~line_s & line_prev_reg;

    // Byte view of the captured frame: byte 0 is the first byte received.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_frame_byte
            assign frame_byte[gi] = shift_reg[39 - 8*gi -: 8];
        end
    endgenerate

    assign sum_calc = frame_byte[0] + frame_byte[1] + frame_byte[2] + frame_byte[3];

    // Any sensor-driven phase that lingers too long aborts the transaction.
    always_comb begin
        timeout_hit = 1'b0;
        case (state_reg)
            S_WAIT_ACK, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH:
                timeout_hit = (us_cnt_reg > TIMEOUT_CNT);
            default: timeout_hit = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      if (start) state_next = S_START_LOW;
            S_START_LOW: if (us_cnt_reg >= START_LOW_CNT) state_next = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (timeout_hit)    state_next = S_IDLE;
                else if (line_fall) state_next = S_RESP_LOW;
            end
            S_RESP_LOW: begin
                if (timeout_hit)    state_next = S_IDLE;
                else if (line_rise) state_next = S_RESP_HIGH;
            end
            S_RESP_HIGH: begin
                if (timeout_hit)    state_next = S_IDLE;
                else if (line_fall) state_next = S_BIT_LOW;
            end
            S_BIT_LOW: begin
                if (timeout_hit)    state_next = S_IDLE;
                else if (line_rise) state_next = S_BIT_HIGH;
            end
            S_BIT_HIGH: begin
                if (timeout_hit) begin
                    state_next = S_IDLE;
                end else if (line_fall) begin
                    // The bit being shifted now is the 40th when the count is 39.
                    state_next = (bit_cnt_reg == 6'd39) ? S_CHECK : S_BIT_LOW;
                end
            end
            S_CHECK:     state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        drive_low = 1'b0;
        busy      = 1'b0;
        case (state_reg)
            S_IDLE:      busy = 1'b0;
            S_START_LOW: begin
                drive_low = 1'b1;
                busy      = 1'b1;
            end
            default:     busy = 1'b1;
        endcase
    end

    // Datapath: phase timer, bit capture, results and status.
    always_ff @(posedge clk) begin
        if (reset) begin
            us_cnt_reg       <= '0;
            bit_cnt_reg      <= '0;
            shift_reg        <= '0;
            done_reg         <= 1'b0;
            checksum_err_reg <= 1'b0;
            timeout_err_reg  <= 1'b0;
            hum_int_reg      <= '0;
            hum_dec_reg      <= '0;
            tem_int_reg      <= '0;
            tem_dec_reg      <= '0;
        end else begin
            done_reg <= 1'b0;

            // The phase timer restarts on every state change.
            if (state_next != state_reg) begin
                us_cnt_reg <= '0;
            end else if (us_tick && (us_cnt_reg != US_MAX)) begin
                us_cnt_reg <= us_cnt_reg + 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        checksum_err_reg <= 1'b0;
                        timeout_err_reg  <= 1'b0;
                        shift_reg        <= '0;
                    end
                end
                S_RESP_HIGH: bit_cnt_reg <= '0;
                S_BIT_HIGH: begin
                    if (line_fall && !timeout_hit) begin
                        shift_reg   <= {shift_reg[38:0], (us_cnt_reg > BIT_THRESH_CNT)};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                S_CHECK: begin
                    done_reg <= 1'b1;
                    if (sum_calc == frame_byte[4]) begin
                        hum_int_reg <= frame_byte[0];
                        hum_dec_reg <= frame_byte[1];
                        tem_int_reg <= frame_byte[2];
                        tem_dec_reg <= frame_byte[3];
                    end else begin
                        checksum_err_reg <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (timeout_hit) begin
                timeout_err_reg <= 1'b1;
                done_reg        <= 1'b1;
            end
        end
    end

    assign done         = done_reg;
    assign checksum_err = checksum_err_reg;
    assign timeout_err  = timeout_err_reg;
    assign hum_int      = hum_int_reg;
    assign hum_dec      = hum_dec_reg;
    assign tem_int      = tem_int_reg;
    assign tem_dec      = tem_dec_reg;
    assign state_dbg    = state_reg;

endmodule

// File: tb/tb_dht11_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dht11_ctrl
//   Self-checking bench for dht11_ctrl with a behavioural DHT11 sensor model
//   on the open-drain line and a frame-level reference model of the results.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dht11_ctrl;

    localparam int CLK_HZ   = 2_000_000;
    localparam int US       = CLK_HZ / 1_000_000;
    localparam int START_US = 20;
    localparam int TO_US    = 255;
    localparam int THR_US   = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       sensor_low = 1'b0;
    wire        dht_io;
    logic       busy;
    logic       done;
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] tem_int;
    logic [7:0] tem_dec;
    logic       checksum_err;
    logic       timeout_err;
    logic [2:0] state_dbg;

    assign dht_io = sensor_low ? 1'b0 : 1'bz;
    pullup (dht_io);

    dht11_ctrl #(
        .CLK_FREQ_HZ  (CLK_HZ),
        .START_LOW_US (START_US),
        .TIMEOUT_US   (TO_US),
        .BIT_THRESH_US(THR_US)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dht_io      (dht_io),
        .busy        (busy),
        .done        (done),
        .hum_int     (hum_int),
        .hum_dec     (hum_dec),
        .tem_int     (tem_int),
        .tem_dec     (tem_dec),
        .checksum_err(checksum_err),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Cycle-level monitor: counts done cycles and done cycles seen with busy high.
    int done_cnt     = 0;
    int busy_at_done = 0;
    always @(negedge clk) begin
        if (done) begin
            done_cnt     <= done_cnt + 1;
            busy_at_done <= busy_at_done + (busy ? 1 : 0);
        end
    end

    // Reference model: results follow from whole frames, not from line timing.
    logic [7:0] m_data [4];
    bit         m_ck;
    bit         m_to;

    task automatic model_txn(input logic [39:0] f, input bit respond, input bit rst_mid);
        int s;
        if (rst_mid) begin
            for (int k = 0; k < 4; k++) m_data[k] = 8'h00;
            m_ck = 1'b0;
            m_to = 1'b0;
        end else if (!respond) begin
            m_to = 1'b1;
            m_ck = 1'b0;
        end else begin
            s = 0;
            for (int k = 0; k < 4; k++) s += int'(f[39 - 8*k -: 8]);
            m_to = 1'b0;
            if ((s % 256) == int'(f[7:0])) begin
                for (int k = 0; k < 4; k++) m_data[k] = f[39 - 8*k -: 8];
                m_ck = 1'b0;
            end else begin
                m_ck = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        n_assert++;
        if (val < lo || val > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input bit low, input int us);
        sensor_low = low;
        repeat (us * US) @(negedge clk);
    endtask

    // One complete transaction: start pulse, host low pulse, then the sensor
    // response (or silence), ending with the done/busy checks.
    task automatic run_frame(input logic [39:0] f, input bit respond, input bit inject,
                             input bit rst_mid, input bit rnd);
        int d0;
        int b0;
        int len;
        int w;
        bit b;
        d0 = done_cnt;
        b0 = busy_at_done;

        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("host_drives_low", dht_io, 0);
        check("errs_cleared_on_start", {checksum_err, timeout_err}, 0);

        len = 0;
        while (dht_io == 1'b0 && len < 200) begin
            len++;
            tick(1);
        end
        check_range("start_low_cycles", len, (START_US - 1) * US, START_US * US + 4);

        if (!respond) begin
            len = 0;
            while (!done && len < 2000) begin
                len++;
                tick(1);
            end
            check_range("timeout_latency_cycles", len, TO_US * US - 2, (TO_US + 2) * US + 4);
            check("timeout_state_idle", state_dbg, 0);
            check("timeout_line_released", dht_io, 1);
            tick(20);
        end else begin
            hold(1'b0, 30);
            hold(1'b1, 80);
            hold(1'b0, 80);
            for (int i = 0; i < 40; i++) begin
                b = f[39 - i];
                if (rnd) w = b ? int'($urandom_range(60, 75)) : int'($urandom_range(20, 30));
                else     w = b ? 70 : 26;
                if (inject && i == 5) begin
                    sensor_low = 1'b1;
                    tick(40);
                    start = 1'b1;
                    tick(1);
                    start = 1'b0;
                    tick(50 * US - 41);
                end else begin
                    hold(1'b1, 50);
                end
                if (rst_mid && i == 20) begin
                    sensor_low = 1'b0;
                    tick(10);
                    reset = 1'b1;
                    tick(1);
                    reset = 1'b0;
                    check("rst_mid_busy", busy, 0);
                    check("rst_mid_state", state_dbg, 0);
                    check("rst_mid_line", dht_io, 1);
                    check("rst_mid_data", {hum_int, hum_dec, tem_int, tem_dec}, 0);
                    check("rst_mid_errs", {checksum_err, timeout_err}, 0);
                    tick(100);
                    check("rst_mid_no_done", done_cnt - d0, 0);
                    return;
                end
                hold(1'b0, w);
            end
            hold(1'b1, 50);
            sensor_low = 1'b0;
            tick(20);
        end
        check("done_pulses", done_cnt - d0, 1);
        check("busy_low_at_done", busy_at_done - b0, 0);
        check("busy_after_done", busy, 0);
        check("state_after_done", state_dbg, 0);
    endtask

    typedef struct {
        logic [39:0] frame;
        bit          respond;
        bit          inject;
        bit          rst_mid;
        logic [31:0] exp_data;
        bit          exp_ck;
        bit          exp_to;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{40'h3700190555, 1'b1, 1'b0, 1'b0, 32'h37001905, 1'b0, 1'b0};
        vecs[1] = '{40'h22001F0354, 1'b1, 1'b0, 1'b0, 32'h37001905, 1'b1, 1'b0};
        vecs[2] = '{40'h0000000000, 1'b0, 1'b0, 1'b0, 32'h37001905, 1'b0, 1'b1};
        vecs[3] = '{40'h4100160259, 1'b1, 1'b1, 1'b0, 32'h41001602, 1'b0, 1'b0};
        vecs[4] = '{40'h3000180048, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0};
        vecs[5] = '{40'hFF807F0200, 1'b1, 1'b0, 1'b0, 32'hFF807F02, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) m_data[k] = 8'h00;
        m_ck = 1'b0;
        m_to = 1'b0;

        reset = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_data", {hum_int, hum_dec, tem_int, tem_dec}, 0);
        check("reset_errs", {checksum_err, timeout_err}, 0);
        check("reset_state", state_dbg, 0);
        check("reset_line", dht_io, 1);

        // start and reset together: reset wins.
        reset = 1'b1;
        start = 1'b1;
        tick(1);
        reset = 1'b0;
        start = 1'b0;
        tick(1);
        check("start_with_reset_busy", busy, 0);
        check("start_with_reset_state", state_dbg, 0);
        $display("txn reset: state=%0d busy=%0d", state_dbg, busy);

        for (int t = 0; t < 6; t++) begin
            run_frame(vecs[t].frame, vecs[t].respond, vecs[t].inject, vecs[t].rst_mid, 1'b0);
            model_txn(vecs[t].frame, vecs[t].respond, vecs[t].rst_mid);
            check("vec_data", {hum_int, hum_dec, tem_int, tem_dec}, vecs[t].exp_data);
            check("vec_checksum_err", checksum_err, vecs[t].exp_ck);
            check("vec_timeout_err", timeout_err, vecs[t].exp_to);
            $display("txn %0d: frame=%h resp=%0d data=%h ck=%0d to=%0d", t, vecs[t].frame,
                     vecs[t].respond, {hum_int, hum_dec, tem_int, tem_dec}, checksum_err, timeout_err);
        end

        for (int r = 0; r < 2; r++) begin
            logic [39:0] f;
            int s;
            f[39:8] = {$urandom};
            s = 0;
            for (int k = 0; k < 4; k++) s += int'(f[39 - 8*k -: 8]);
            f[7:0] = 8'(s);
            if ($urandom_range(0, 1) == 0) f[7:0] = f[7:0] + 8'($urandom_range(1, 255));
            run_frame(f, 1'b1, 1'b0, 1'b0, 1'b1);
            model_txn(f, 1'b1, 1'b0);
            check("rand_data", {hum_int, hum_dec, tem_int, tem_dec},
                  {m_data[0], m_data[1], m_data[2], m_data[3]});
            check("rand_checksum_err", checksum_err, m_ck);
            check("rand_timeout_err", timeout_err, m_to);
            $display("txn rand%0d: frame=%h data=%h ck=%0d to=%0d", r, f,
                     {hum_int, hum_dec, tem_int, tem_dec}, checksum_err, timeout_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        repeat (120000) @(posedge clk);
        $display("FAIL watchdog: got no end of test, expected finish within 120000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
